jpeg_out_stream_ctrl: RTL and testbench

//  Parametrised JPEG bitstream capture controller placed after the encoder core (jenc), in the encoder clock domain.

---
 rtl/jpeg_out_stream_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_jpeg_out_stream_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_out_stream_ctrl.sv
// JPEG bitstream capture controller: paces encoder words out with a byte
// address, optional byte swap, image size latch and overflow drain.
// Ports:
//   clk, resetn          : encoder clock, async active-low reset
//   start_capture_in     : arm a capture (pulse)
//   continuous_in        : re-arm automatically after each frame
//   abort_in             : abandon capture, back to idle
//   swap_in              : reverse byte order of each accepted word
//   frame_start_in       : sensor frame start pulse
//   in_data/in_valid/in_tlast/in_hold : encoder word stream with stall
//   data_out/address_out/data_valid_out : written word, byte offset, strobe
//   image_valid_out/image_size_out      : finished image and its size
//   overflow_out         : last image exceeded the buffer
//   frame_count_out      : completed images since reset
module jpeg_out_stream_ctrl #(
    parameter int DW_BYTES  = 4,
    parameter int ADDR_W    = 20,
    parameter int GAP       = 1,
    parameter int MAX_BYTES = 65536
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start_capture_in,
    input  logic                    continuous_in,
    input  logic                    abort_in,
    input  logic                    swap_in,
    input  logic                    frame_start_in,
    input  logic [8*DW_BYTES-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_tlast,
    output logic                    in_hold,
    output logic [8*DW_BYTES-1:0]   data_out,
    output logic [ADDR_W-1:0]       address_out,
    output logic                    data_valid_out,
    output logic                    image_valid_out,
    output logic [ADDR_W-1:0]       image_size_out,
    output logic                    overflow_out,
    output logic [7:0]              frame_count_out
);

    localparam int DW = 8 * DW_BYTES;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [DW-1:0]       data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                dv_q, dv_d;
    logic [ADDR_W-1:0]   size_q, size_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          fc_q, fc_d;

    logic [DW-1:0]       swapped;
    logic                accept;
    logic                fits;
    logic [63:0]         need;

    always_comb begin
        swapped = '0;
        for (int i = 0; i < DW_BYTES; i++) begin
            swapped[8*i +: 8] = in_data[8*(DW_BYTES-1-i) +: 8];
        end
    end

    // Stall depends on state only, so the producer sees a stable value.
    always_comb begin
        in_hold = 1'b1;
        unique case (state_q)
            S_CAPTURE: in_hold = (gap_q != '0);
            S_DRAIN:   in_hold = 1'b0;
            default:   in_hold = 1'b1;
        endcase
    end

    assign accept = in_valid & ~in_hold;
    assign need   = 64'(count_q) + 64'(DW_BYTES);
    assign fits   = (need <= 64'(MAX_BYTES));

    always_comb begin
        state_d = state_q;
        gap_d   = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        count_d = count_q;
        data_d  = data_q;
        addr_d  = addr_q;
        dv_d    = 1'b0;
        size_d  = size_q;
        ovf_d   = ovf_q;
        fc_d    = fc_q;
        if (abort_in) begin
            state_d = S_IDLE;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_capture_in) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (frame_start_in) begin
                        state_d = S_CAPTURE;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        gap_d   = '0;
                    end
                end
                S_CAPTURE: begin
                    if (accept && fits) begin
                        dv_d    = 1'b1;
                        addr_d  = count_q;
                        data_d  = swap_in ? swapped : in_data;
                        count_d = count_q + ADDR_W'(DW_BYTES);
                        gap_d   = GW'(GAP);
                        if (in_tlast) begin
                            state_d = S_DONE;
                            size_d  = count_q + ADDR_W'(DW_BYTES);
                            fc_d    = fc_q + 8'd1;
                        end
                    end else if (accept) begin
                        // Word would cross the buffer end: drop it.
                        ovf_d = 1'b1;
                        if (in_tlast) begin
                            state_d = S_DONE;
                            size_d  = count_q;
                            fc_d    = fc_q + 8'd1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept && in_tlast) begin
                        state_d = S_DONE;
                        size_d  = count_q;
                        fc_d    = fc_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (continuous_in || start_capture_in) state_d = S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            dv_q    <= 1'b0;
            size_q  <= '0;
            ovf_q   <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            dv_q    <= dv_d;
            size_q  <= size_d;
            ovf_q   <= ovf_d;
            fc_q    <= fc_d;
        end
    end

    assign data_out        = data_q;
    assign address_out     = addr_q;
    assign data_valid_out  = dv_q;
    assign image_valid_out = (state_q == S_DONE);
    assign image_size_out  = size_q;
    assign overflow_out    = ovf_q;
    assign frame_count_out = fc_q;

endmodule

// File: tb/tb_jpeg_out_stream_ctrl.sv
// Bench for jpeg_out_stream_ctrl: vector table, directed corner sequences
// and randomized frames checked against a frame-level expectation.
module tb_jpeg_out_stream_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        start, cont, abort, swp, fs, va, vb, tlast;
    logic [31:0] din;

    logic        a_hold, a_dv, a_iv, a_ovf;
    logic [31:0] a_dout;
    logic [19:0] a_addr, a_size;
    logic [7:0]  a_fc;
    logic        b_hold, b_dv, b_iv, b_ovf;
    logic [31:0] b_dout;
    logic [19:0] b_addr, b_size;
    logic [7:0]  b_fc;

    jpeg_out_stream_ctrl #(
        .DW_BYTES(4), .ADDR_W(20), .GAP(1), .MAX_BYTES(40)
    ) dut_a (
        .clk(clk), .resetn(resetn),
        .start_capture_in(start), .continuous_in(cont),
        .abort_in(abort), .swap_in(swp), .frame_start_in(fs),
        .in_data(din), .in_valid(va), .in_tlast(tlast),
        .in_hold(a_hold), .data_out(a_dout), .address_out(a_addr),
        .data_valid_out(a_dv), .image_valid_out(a_iv),
        .image_size_out(a_size), .overflow_out(a_ovf),
        .frame_count_out(a_fc)
    );

    jpeg_out_stream_ctrl #(
        .DW_BYTES(4), .ADDR_W(20), .GAP(0), .MAX_BYTES(8)
    ) dut_b (
        .clk(clk), .resetn(resetn),
        .start_capture_in(start), .continuous_in(cont),
        .abort_in(abort), .swap_in(swp), .frame_start_in(fs),
        .in_data(din), .in_valid(vb), .in_tlast(tlast),
        .in_hold(b_hold), .data_out(b_dout), .address_out(b_addr),
        .data_valid_out(b_dv), .image_valid_out(b_iv),
        .image_size_out(b_size), .overflow_out(b_ovf),
        .frame_count_out(b_fc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int b_adj = 0;
    int fce [2];
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic [51:0] qa [$];
    logic [51:0] qb [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (a_dv) begin
            chk("a_gap", {63'd0, prev_a}, 64'd0);
            qa.push_back({a_addr, a_dout});
        end
        if (b_dv) begin
            if (prev_b) b_adj++;
            qb.push_back({b_addr, b_dout});
        end
        prev_a = a_dv;
        prev_b = b_dv;
    end

    typedef struct {
        logic        st, fsv, v, tl;
        logic [31:0] d;
        logic        hold, dv;
        logic [19:0] addr;
        logic [31:0] dout;
        logic        iv;
        logic [19:0] size;
        logic [7:0]  fc;
    } vec_t;

    vec_t tbl [8];

    // One frame on the selected DUT; expectations from buffer capacity.
    task automatic run_frame(input int sel, input int n, input logic sw,
                             input logic do_start, input logic bub);
        logic [31:0] w [16];
        logic [51:0] e;
        int k, budget, cap, wr;
        logic h, v;
        for (int j = 0; j < 16; j++) w[j] = $urandom;
        cap = (sel == 1) ? 2 : 10;
        wr = (n < cap) ? n : cap;
        qa.delete();
        qb.delete();
        swp = sw;
        if (do_start) begin
            start = 1'b1; cyc(); start = 1'b0;
        end else begin
            cyc();
            chk("iv_drop", sel ? b_iv : a_iv, 0);
        end
        fs = 1'b1; cyc(); fs = 1'b0;
        k = 0;
        budget = 0;
        while (k < n && budget < 400) begin
            h = sel ? b_hold : a_hold;
            v = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
            din = w[k];
            tlast = (k == n - 1);
            if (sel == 1) vb = v; else va = v;
            cyc();
            if (v && !h) k++;
            budget++;
        end
        va = 1'b0; vb = 1'b0; tlast = 1'b0;
        chk("frm_words", k, n);
        chk("frm_iv", sel ? b_iv : a_iv, 1);
        chk("frm_size", sel ? b_size : a_size, 4 * wr);
        chk("frm_ovf", sel ? b_ovf : a_ovf, (n > cap) ? 1 : 0);
        fce[sel] = (fce[sel] + 1) % 256;
        chk("frm_fc", sel ? b_fc : a_fc, fce[sel]);
        #1;
        chk("frm_nwr", sel ? qb.size() : qa.size(), wr);
        for (int j = 0; j < wr; j++) begin
            e = {20'(4 * j), sw ? bswap(w[j]) : w[j]};
            if (sel == 1 && j < qb.size()) chk("frm_word", qb[j], e);
            if (sel == 0 && j < qa.size()) chk("frm_word", qa[j], e);
        end
    endtask

    initial begin
        start = 0; cont = 0; abort = 0; swp = 0; fs = 0;
        va = 0; vb = 0; tlast = 0; din = '0;
        fce[0] = 0; fce[1] = 0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,
                   1'b1, 1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11223344,
                   1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h11223344,
                   1'b1, 1'b1, 20'd0, 32'h44332211, 1'b0, 20'd0, 8'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h55667788,
                   1'b0, 1'b0, 20'd0, 32'h44332211, 1'b0, 20'd0, 8'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h55667788,
                   1'b1, 1'b1, 20'd4, 32'h88776655, 1'b0, 20'd0, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h99AABBCC,
                   1'b0, 1'b0, 20'd4, 32'h88776655, 1'b0, 20'd0, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h99AABBCC,
                   1'b1, 1'b1, 20'd8, 32'hCCBBAA99, 1'b1, 20'd12, 8'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                   1'b1, 1'b0, 20'd8, 32'hCCBBAA99, 1'b1, 20'd12, 8'd1};

        cyc(); cyc();
        chk("rst_hold", a_hold, 1);
        chk("rst_dv", a_dv, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_iv", a_iv, 0);
        chk("rst_fc", a_fc, 0);
        chk("rst_b_hold", b_hold, 1);
        resetn = 1'b1;
        cyc();

        swp = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].st; fs = tbl[i].fsv;
            va = tbl[i].v; tlast = tbl[i].tl; din = tbl[i].d;
            cyc();
            chk($sformatf("t%0d_hold", i), a_hold, tbl[i].hold);
            chk($sformatf("t%0d_dv", i), a_dv, tbl[i].dv);
            chk($sformatf("t%0d_addr", i), a_addr, tbl[i].addr);
            chk($sformatf("t%0d_dout", i), a_dout, tbl[i].dout);
            chk($sformatf("t%0d_iv", i), a_iv, tbl[i].iv);
            chk($sformatf("t%0d_size", i), a_size, tbl[i].size);
            chk($sformatf("t%0d_fc", i), a_fc, tbl[i].fc);
        end
        start = 0; fs = 0; va = 0; tlast = 0;
        fce[0] = 1;

        abort = 1'b1; cyc(); abort = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        fs = 1'b1; cyc(); fs = 1'b0;
        va = 1'b1; din = 32'hA5A50001; cyc();
        chk("ab_dv1", a_dv, 1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("ab_dv0", a_dv, 0);
        chk("ab_hold", a_hold, 1);
        chk("ab_iv", a_iv, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ab_idle_dv", a_dv, 0);
            chk("ab_idle_hold", a_hold, 1);
        end
        fs = 1'b1; cyc(); fs = 1'b0;
        chk("ab_fs_hold", a_hold, 1);
        va = 1'b0;

        start = 1'b1; cyc(); start = 1'b0;
        fs = 1'b1; cyc(); fs = 1'b0;
        va = 1'b1; din = 32'h01020304; cyc(); va = 1'b0;
        chk("ar_pre_dv", a_dv, 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_dv", a_dv, 0);
        chk("ar_dout", a_dout, 0);
        chk("ar_addr", a_addr, 0);
        chk("ar_size", a_size, 0);
        chk("ar_fc", a_fc, 0);
        chk("ar_ovf", a_ovf, 0);
        chk("ar_iv", a_iv, 0);
        chk("ar_hold", a_hold, 1);
        cyc();
        resetn = 1'b1;
        fce[0] = 0; fce[1] = 0;
        cyc();

        cont = 1'b1;
        run_frame(0, 2, 1'b0, 1'b1, 1'b0);
        run_frame(0, 2, 1'b1, 1'b0, 1'b0);
        chk("cont_fc", a_fc, 2);
        cont = 1'b0;

        abort = 1'b1; cyc(); abort = 1'b0;
        b_adj = 0;
        run_frame(1, 5, 1'b1, 1'b1, 1'b0);
        chk("b_b2b", b_adj, 1);
        run_frame(1, 3, 1'b0, 1'b1, 1'b0);

        abort = 1'b1; cyc(); abort = 1'b0;
        for (int r = 0; r < 25; r++) begin
            run_frame(0, $urandom_range(1, 14), 1'($urandom_range(0, 1)),
                      1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
